rover_visit_monitor: RTL
========================

Name: rover_visit_monitor

Overview:
- Downstream consumer of the rover location FSM's 3-bit current_loc output.
- Detects every room change and pushes a departure event {room, dwell cycles} into a small valid/ready FIFO for the logging/telemetry stage.
- Keeps saturating per-room entry counters and raises an infection-zone alert while the rover is inside an isolation-class room.
- Room codes: HNR=000, IR=001, CPR=010, ABIR=011, NPR=100, ICU=101, CCU=110, BU=111.

Parameters:
- DWELL_W, 8, width of dwell counter and evt_dwell; saturates at all-ones.
- VISIT_W, 4, width of each per-room entry counter; saturates at all-ones.
- FIFO_DEPTH, 4, event FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- current_loc  in  3  room code from the location FSM, sampled every rising edge.
- evt_valid  out  1  FIFO non-empty; head event presented.
- evt_ready  in  1  consumer accepts head event when evt_valid=1.
- evt_room  out  3  room code departed (head entry).
- evt_dwell  out  DWELL_W  cycles spent in evt_room (head entry).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held.
- overflow  out  1  sticky; an event was dropped.
- infect_alert  out  1  registered; prev_loc in {IR, ABIR, NPR, CCU}.
- visit_sel  in  3  room whose entry counter is read.
- visit_count  out  VISIT_W  combinational read of entry counter[visit_sel].
- illegal_trans  out  1  sticky illegal-transition flag (see Optional Feature).

Behaviour:
- Reset (reset=0, async): prev_loc=000, dwell_cnt=0, all 8 entry counters=0, FIFO empty, evt_valid=0, fifo_count=0, overflow=0, infect_alert=0, illegal_trans=0. evt_room/evt_dwell=0 when empty. Reset mid-operation discards all queued events.
- Every rising edge, compare current_loc with prev_loc:
  - Equal: dwell_cnt <= dwell_cnt+1, saturating at 2^DWELL_W-1.
  - Different (change): push {prev_loc, dwell_cnt}; prev_loc <= current_loc; dwell_cnt <= 0; entry counter[current_loc] +1, saturating.
- Dwell definition: the number of sampling edges at which current_loc equalled prev_loc before the change. The FSM leaves every non-HNR room after one cycle, so those events normally carry dwell 0.
- Latency: evt_valid rises on the edge that samples the change (1 cycle), when the FIFO was empty.
- FIFO handshake:
  - Pop when evt_valid && evt_ready at a rising edge. Head data holds stable while evt_valid=1 and evt_ready=0.
  - Push and pop in the same cycle: both take effect and fifo_count is unchanged.
  - Push on a full FIFO with a simultaneous pop: accepted.
  - Push on a full FIFO without a pop: the new event is dropped and overflow <= 1. overflow clears only on reset.
  - Pop on empty: ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- infect_alert updates one edge after prev_loc changes and reflects the registered prev_loc.

Optional Feature:
- Macro: ROVER_TRANSIT_CHECK_EN.
- Defined: each change is checked against the legal-move table:
  - HNR->IR
  - IR->ICU/HNR
  - CPR->BU/ABIR
  - ABIR->NPR/HNR
  - NPR->ICU/HNR
  - ICU->CPR/NPR
  - CCU->ABIR/HNR
  - BU->ICU/CCU
- Any other change sets illegal_trans=1 (sticky until reset). The event is still logged.
- Undefined: no check logic; illegal_trans is tied to 0.

Test Plan:
- Reset release, current_loc=000 for 5 edges, then 001 -> one event {000, 5}; evt_valid=1 one edge later; visit_count(sel=001)=1.
- Sequence 000->001->101->010 with evt_ready=1 held -> events {000,n}, {001,0}, {101,0} in order; fifo_count never exceeds 1; overflow=0.
- evt_ready=0, 5 changes with FIFO_DEPTH=4 -> fifo_count=4, overflow=1, first 4 events retained; raising evt_ready drains them in order.
- Hold current_loc=000 for 300 edges with DWELL_W=8, then change -> evt_dwell=255. Enter IR 20 times with VISIT_W=4 -> visit_count=15.
- Enter CCU (110) -> infect_alert=1 one edge later. Move to ABIR -> stays 1. Move to HNR -> drops to 0.
- With ROVER_TRANSIT_CHECK_EN defined, 000->111 -> illegal_trans=1 and event still logged. Without the macro -> illegal_trans=0. Assert reset mid-burst -> FIFO empty, all flags 0.

Source files
------------

// File: rtl/rover_visit_monitor.sv
// rover_visit_monitor
//   Watches the location FSM's current_loc, logs each departure as
//   {room, dwell} into a valid/ready FIFO, keeps saturating per-room entry
//   counters and raises infect_alert while the registered room is one of
//   IR, ABIR, NPR or CCU.
//
//   Optional: define ROVER_TRANSIT_CHECK_EN to check each room change
//   against the legal-move table and set a sticky illegal_trans flag.
//   When the macro is undefined, illegal_trans is tied to 0.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   current_loc   room code, sampled every edge
//   evt_valid     FIFO non-empty, head event presented
//   evt_ready     consumer accepts head event
//   evt_room      departed room of the head event (0 when empty)
//   evt_dwell     dwell cycles of the head event (0 when empty)
//   fifo_count    entries held
//   overflow      sticky, an event was dropped on a full FIFO
//   infect_alert  registered isolation-room alert
//   visit_sel     room whose entry counter is read
//   visit_count   entry counter of visit_sel (combinational)
//   illegal_trans sticky illegal-transition flag
module rover_visit_monitor #(
  parameter int unsigned DWELL_W    = 8,
  parameter int unsigned VISIT_W    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    current_loc,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [2:0]                    evt_room,
  output logic [DWELL_W-1:0]            evt_dwell,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          infect_alert,
  input  logic [2:0]                    visit_sel,
  output logic [VISIT_W-1:0]            visit_count,
  output logic                          illegal_trans
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    HNR  = 3'd0,
    IR   = 3'd1,
    CPR  = 3'd2,
    ABIR = 3'd3,
    NPR  = 3'd4,
    ICU  = 3'd5,
    CCU  = 3'd6,
    BU   = 3'd7
  } room_t;

  logic [2:0]         prev_loc;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [VISIT_W-1:0] visits [8];

  logic [2:0]         fifo_room  [FIFO_DEPTH];
  logic [DWELL_W-1:0] fifo_dwell [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic change;
  logic pop;
  logic full;
  logic push_ok;

  always_comb begin
    change  = (current_loc != prev_loc);
    pop     = (count != '0) && evt_ready;
    full    = (count == CNT_W'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok = change && (!full || pop);
  end

  // Room tracker: dwell and entry counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_loc  <= HNR;
      dwell_cnt <= '0;
      for (int unsigned i = 0; i < 8; i++) visits[i] <= '0;
    end else if (change) begin
      prev_loc  <= current_loc;
      dwell_cnt <= '0;
      if (visits[current_loc] != '1)
        visits[current_loc] <= visits[current_loc] + 1'b1;
    end else if (dwell_cnt != '1) begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  // Event FIFO storage (no reset needed: guarded by count).
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_room[wr_ptr]  <= prev_loc;
      fifo_dwell[wr_ptr] <= dwell_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (change && full && !pop) overflow <= 1'b1;
    end
  end

  // Alert follows the registered room, so it lags prev_loc by one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      infect_alert <= 1'b0;
    end else begin
      case (prev_loc)
        IR, ABIR, NPR, CCU: infect_alert <= 1'b1;
        default:            infect_alert <= 1'b0;
      endcase
    end
  end

`ifdef ROVER_TRANSIT_CHECK_EN
  function automatic logic legal_move(input logic [2:0] from, input logic [2:0] to);
    case (from)
      HNR:     return (to == IR);
      IR:      return (to == ICU)  || (to == HNR);
      CPR:     return (to == BU)   || (to == ABIR);
      ABIR:    return (to == NPR)  || (to == HNR);
      NPR:     return (to == ICU)  || (to == HNR);
      ICU:     return (to == CPR)  || (to == NPR);
      CCU:     return (to == ABIR) || (to == HNR);
      BU:      return (to == ICU)  || (to == CCU);
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      illegal_trans <= 1'b0;
    else if (change && !legal_move(prev_loc, current_loc))
      illegal_trans <= 1'b1;
  end
`else
  assign illegal_trans = 1'b0;
`endif

  assign evt_valid   = (count != '0);
  assign evt_room    = evt_valid ? fifo_room[rd_ptr]  : '0;
  assign evt_dwell   = evt_valid ? fifo_dwell[rd_ptr] : '0;
  assign fifo_count  = count;
  assign visit_count = visits[visit_sel];

endmodule
